// File: rtl/mdu_ctrl_pkg.sv
// Shared encodings for the EX-stage multiply/divide controller: operation codes,
// FSM states and the divider handshake levels used by the existing datapath.
package mdu_defs;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } mdu_state_e;

  localparam logic DivStart       = 1'b1;
  localparam logic DivStop        = 1'b0;
  localparam logic DivResultReady = 1'b1;

  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/hilo_reg.sv
// Architectural HI/LO register pair with independent write enables.
module hilo_reg (
  input  logic        clk,
  input  logic        resetn,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] hi_d,
  input  logic [31:0] lo_d,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi <= '0;
      lo <= '0;
    end else begin
      if (hi_we) hi <= hi_d;
      if (lo_we) lo <= lo_d;
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// EX-stage multiply/divide sequencer: drives the fixed-latency multiplier and the
// handshaked divider, stalls EX until the result is ready, then commits HI/LO once.
module mdu_ctrl
  import mdu_defs::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        ex_stall,
  input  logic        flush,
  output logic        stallreq,
  output logic        busy,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic        div_annul,
  output logic [31:0] div_opdata1,
  output logic [31:0] div_opdata2,
  input  logic [63:0] div_result,
  input  logic        div_ready,
  output logic [1:0]  state_dbg
);

  // Handshake: div_start stays high for every DIV cycle; the divider raises
  // div_ready with div_result valid in the same cycle; div_annul aborts it.

  mdu_state_e  state;
  logic [2:0]  cnt;
  logic [63:0] res;
  logic [31:0] opa, opb;
  logic        sgn;
  logic        op_is_mul;
  logic        commit_en;

  logic start_mul, start_div;
  logic hi_we, lo_we;
  logic [31:0] hi_d, lo_d;
  logic mt_ok;

  assign start_mul = op_valid && is_mul_op(md_op) && !flush;
  assign start_div = op_valid && is_div_op(md_op) && !flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      res       <= '0;
      opa       <= '0;
      opb       <= '0;
      sgn       <= 1'b0;
      op_is_mul <= 1'b0;
      commit_en <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_mul) begin
            state     <= S_MUL;
            cnt       <= 3'(MUL_LAT);
            opa       <= src_a;
            opb       <= src_b;
            sgn       <= (md_op == MD_MULT);
            op_is_mul <= 1'b1;
            commit_en <= 1'b1;
          end else if (start_div) begin
            opa       <= src_a;
            opb       <= src_b;
            sgn       <= (md_op == MD_DIV);
            op_is_mul <= 1'b0;
            // Divide by zero skips the divider and leaves HI/LO untouched.
            if (src_b != '0) begin
              state     <= S_DIV;
              commit_en <= 1'b1;
            end else begin
              state     <= S_DONE;
              commit_en <= 1'b0;
            end
          end
        end
        S_MUL: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            res   <= mul_result;
            state <= S_DONE;
          end
        end
        S_DIV: begin
          if (div_ready == DivResultReady) begin
            res   <= div_result;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (!ex_stall) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // HI/LO writes: the DONE commit or a move-to in IDLE, both blocked by stall/flush.
  assign mt_ok = (state == S_IDLE) && op_valid && !ex_stall && !flush;
  always_comb begin
    hi_we = 1'b0;
    lo_we = 1'b0;
    hi_d  = src_a;
    lo_d  = src_a;
    if (state == S_DONE) begin
      hi_we = commit_en && !ex_stall && !flush;
      lo_we = commit_en && !ex_stall && !flush;
      hi_d  = res[63:32];
      lo_d  = res[31:0];
    end else begin
      hi_we = mt_ok && (md_op == MD_MTHI);
      lo_we = mt_ok && (md_op == MD_MTLO);
    end
  end

  hilo_reg u_hilo (
    .clk    (clk),
    .resetn (resetn),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .hi_d   (hi_d),
    .lo_d   (lo_d),
    .hi     (hi_o),
    .lo     (lo_o)
  );

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;
  // Gated by resetn so the request is low while reset is held, whatever EX shows.
  assign stallreq  = resetn &&
                     (((state == S_IDLE) && (start_mul || start_div)) ||
                      (state == S_MUL) || (state == S_DIV));

  assign div_start  = (state == S_DIV) ? DivStart : DivStop;
  assign div_annul  = (state == S_DIV) && flush;

  assign mul_signed  = busy && op_is_mul && sgn;
  assign mul_ina     = (busy && op_is_mul) ? opa : '0;
  assign mul_inb     = (busy && op_is_mul) ? opb : '0;
  assign div_signed  = busy && !op_is_mul && sgn;
  assign div_opdata1 = (busy && !op_is_mul) ? opa : '0;
  assign div_opdata2 = (busy && !op_is_mul) ? opb : '0;

endmodule
